pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement integer adder/subtractor with valid/ready handshakes on both sides. It splits a WIDTH-bit add into STAGES equal ripple-carry chunks, one chunk per register rank, and carries the inter-chunk carry between ranks. It replaces the fixed 16-bit combinational adder in the floating-point datapath, where it serves the mantissa add/subtract and exponent arithmetic at higher clock rates.

---
 rtl/adder_pkg.sv | 16 +
 rtl/rca_chunk.sv | 20 ++
 rtl/pipelined_adder.sv | 77 +++++++
 tb/tb_pipelined_adder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and elaboration checks for pipelined_adder.
package adder_pkg;
   localparam int MAX_W = 64;
   typedef struct packed {
      logic             valid;
      logic             sub;
      logic             c;
      logic             cm;
      logic [MAX_W-1:0] s;
      logic [MAX_W-1:0] a;
      logic [MAX_W-1:0] b;
   } rank_t;
   function automatic bit width_ok(int w, int st);
      return st > 0 && w > 0 && w <= MAX_W && w % st == 0;
   endfunction
endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: combinational N-bit ripple-carry adder of full-adder cells.
module rca_chunk #(
   parameter int N = 8
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co,
   output logic         cm
);
   logic [N:0] c;
   assign c[0] = ci;
   for (genvar i = 0; i < N; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end
   assign co = c[N];
   assign cm = c[N-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-rank ripple adder/subtractor, one CHUNK per rank,
// with valid/ready flow control and per-rank bubble collapsing.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CHUNK = WIDTH / STAGES;
   localparam int L = STAGES - 1;
   if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and <= MAX_W");
   end
   rank_t head;
   rank_t src [STAGES];
   rank_t r [STAGES];
   logic [STAGES:0] rdy;
   always_comb begin
      head       = '0;
      head.valid = in_valid;
      head.sub   = sub;
      head.c     = sub ? ~cin : cin;
      head.a     = MAX_W'(a);
      head.b     = MAX_W'(sub ? ~b : b);
   end
   assign rdy[STAGES] = out_ready;
   assign in_ready    = rst_n & rdy[0];
   for (genvar k = 0; k < STAGES; k++) begin : g_rank
      logic [CHUNK-1:0] cs;
      logic co, cm;
      rank_t n, q;
      if (k == 0) begin : g_head
         assign src[k] = head;
      end else begin : g_link
         assign src[k] = r[k-1];
      end
      rca_chunk #(.N(CHUNK)) u_rca (
         .x (src[k].a[k*CHUNK +: CHUNK]),
         .y (src[k].b[k*CHUNK +: CHUNK]),
         .ci(src[k].c),
         .s (cs),
         .co(co),
         .cm(cm)
      );
      always_comb begin
         n                      = src[k];
         n.s[k*CHUNK +: CHUNK]  = cs;
         n.c                    = co;
         n.cm                   = cm;
      end
      // A rank that cannot pass its beat on keeps everything it holds.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) q <= '0;
         else if (rdy[k]) q <= n;
      end
      assign r[k]   = q;
      assign rdy[k] = !q.valid || rdy[k+1];
   end
   assign out_valid = r[L].valid;
   assign sum       = r[L].s[WIDTH-1:0];
   assign cout      = r[L].c;
   assign ovf       = r[L].cm ^ r[L].c;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed scoreboard bench for a 32/4 and a 16/1 instance.
module tb_pipelined_adder;
   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic        ov;
   } exp_t;

   logic clk = 0;
   logic rst_n = 0;
   always #5 clk = ~clk;

   logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
   logic [31:0] a = 0, b = 0, sum;
   logic        cin = 0, sub = 0, cout, ovf;

   logic        in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 1;
   logic [15:0] a1 = 0, b1 = 0, sum1;
   logic        cin1 = 0, sub1 = 0, cout1, ovf1;

   pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   pipelined_adder #(.WIDTH(16), .STAGES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .sub(sub1), .out_valid(out_valid1),
      .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   exp_t sb[$];
   exp_t sb1[$];
   int n_cmp = 0;
   int n_err = 0;

   function automatic exp_t model(logic [31:0] x, logic [31:0] y, logic ci, logic s, int w);
      logic [63:0] m, bf, full, low;
      logic c0;
      exp_t e;
      m    = (64'd1 << w) - 64'd1;
      c0   = s ? ~ci : ci;
      bf   = s ? (~{32'd0, y}) & m : {32'd0, y};
      full = {32'd0, x} + bf + 64'(c0);
      low  = ({32'd0, x} & (m >> 1)) + (bf & (m >> 1)) + 64'(c0);
      e.s  = full[31:0] & m[31:0];
      e.co = full[w];
      e.ov = low[w-1] ^ full[w];
      return e;
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   logic        held = 0;
   logic [31:0] h_sum;
   logic        h_co, h_ov;
   exp_t        e, e1;

   always @(negedge clk) begin
      if (!rst_n) begin
         held = 0;
      end else begin
         if (held) begin
            chk("stable_sum", sum, h_sum);
            chk("stable_cout", cout, h_co);
            chk("stable_ovf", ovf, h_ov);
         end
         held  = out_valid && !out_ready;
         h_sum = sum;
         h_co  = cout;
         h_ov  = ovf;
         if (out_valid && out_ready) begin
            chk("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("sum", sum, e.s);
               chk("cout", cout, e.co);
               chk("ovf", ovf, e.ov);
            end
         end
         if (out_valid1 && out_ready1) begin
            chk("sb1_has_entry", sb1.size() != 0, 1);
            if (sb1.size() != 0) begin
               e1 = sb1.pop_front();
               chk("sum1", sum1, e1.s[15:0]);
               chk("cout1", cout1, e1.co);
            end
         end
      end
   end

   task automatic send(logic [31:0] x, logic [31:0] y, logic ci, logic s);
      a = x;
      b = y;
      cin = ci;
      sub = s;
      in_valid = 1;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (in_ready) break;
         if (t >= 100) begin
            chk("send_timeout", in_ready, 1);
            break;
         end
         @(posedge clk);
         #1;
      end
      if (in_ready) sb.push_back(model(x, y, ci, s, 32));
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && (sb.size() != 0 || out_valid); t++) @(negedge clk);
      chk("drain_empty", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      out_ready = 1;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      #1;
      chk("in_ready_after_rst", in_ready, 1);

      send(32'hFFFFFFFF, 32'h00000001, 0, 0);
      chk("lat_edge_t", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_edge_t1", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_edge_t2", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_edge_t3", out_valid, 1);
      drain();

      send(32'h7FFFFFFF, 32'h00000000, 1, 0);
      send(32'h80000000, 32'h00000001, 0, 1);
      send(32'h00000000, 32'h00000001, 0, 1);
      send(32'h12345678, 32'h9ABCDEF0, 1, 1);
      send(32'hDEADBEEF, 32'h21524111, 1, 0);
      drain();

      out_ready = 0;
      for (int i = 0; i < 4; i++) send(32'(i), 32'(i) << 16, 0, 0);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("bp_still_blocked", in_ready, 0);
      out_ready = 1;
      #1;
      chk("bp_ready_comb", in_ready, 1);
      for (int i = 4; i < 8; i++) send(32'(i), 32'(i) << 16, 0, 0);
      drain();

      out_ready = 0;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         a = 32'h1000 * i + 3;
         b = 32'hF0F0F0F0 ^ 32'(i);
         cin = i[0];
         sub = i[1];
         in_valid = (i % 2 == 0);
         @(negedge clk);
         if (in_valid && in_ready) begin
            acc++;
            sb.push_back(model(a, b, cin, sub, 32));
         end
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      chk("bubble_accepted", acc, 4);
      chk("bubble_full", in_ready, 0);
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bubble_drain_consec", out_valid, 1);
      end
      @(negedge clk);
      chk("bubble_drained", out_valid, 0);
      chk("bubble_sb_empty", sb.size(), 0);
      @(posedge clk);
      #1;

      out_ready = 0;
      for (int i = 0; i < 3; i++) send(32'hFFFFFFFF - 32'(i), 32'hFFFFFFFF, 0, 0);
      @(posedge clk);
      #1;
      chk("pre_rst_valid", out_valid, 1);
      rst_n = 0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_cout", cout, 0);
      chk("mid_rst_ovf", ovf, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1;
      out_ready = 1;
      repeat (8) @(negedge clk);
      chk("no_stale_beat", out_valid, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 20; i++) begin
         a1 = 16'($urandom);
         b1 = 16'($urandom);
         cin1 = 1'($urandom_range(0, 1));
         in_valid1 = 1;
         @(negedge clk);
         chk("small_in_ready", in_ready1, 1);
         sb1.push_back(model({16'd0, a1}, {16'd0, b1}, cin1, 0, 16));
         @(posedge clk);
         #1;
         chk("small_latency", out_valid1, 1);
      end
      in_valid1 = 0;
      @(negedge clk);
      @(negedge clk);
      chk("small_sb_empty", sb1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
